// File: rtl/interfaz_botones.sv
// Button event interface: queues button codes on each filtered press and exposes
// them through a small register bus (STATUS, DATA, CTRL, TOTAL) with a level interrupt.
module interfaz_botones #(
  parameter int PROFUNDIDAD = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        pulso_i,
  input  logic [3:0]  botones_i,
  input  logic        cs_i,
  input  logic        we_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        irq_o
);

  localparam int PTR_W = $clog2(PROFUNDIDAD);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] ADDR_STATUS = 2'd0;
  localparam logic [1:0] ADDR_DATA   = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_TOTAL  = 2'd3;

  logic [3:0]       fifoMem [PROFUNDIDAD];

  logic [PTR_W-1:0] wrPtrReg, wrPtrNext;
  logic [PTR_W-1:0] rdPtrReg, rdPtrNext;
  logic [CNT_W-1:0] countReg, countNext;
  logic             ovfReg, ovfNext;
  logic             irqEnReg, irqEnNext;
  logic [15:0]      totalReg, totalNext;
  logic [31:0]      rdataReg, rdataNext;
  logic             irqReg, irqNext;

  logic             busRead, busWrite;
  logic             fifoEmpty, fifoFull;
  logic             popEvt, pushEvt, dropEvt, flushEvt, ovfClear;
  logic             ctrlWrite, totalWrite;
  logic [PTR_W-1:0] wrAddr;
  logic [31:0]      statusWord, dataWord, readMux;
  logic             unusedWdata;

  assign unusedWdata = ^wdata_i[31:3];

  // Bus decode
  assign busRead    = cs_i & ~we_i;
  assign busWrite   = cs_i & we_i;
  assign ctrlWrite  = busWrite & (addr_i == ADDR_CTRL);
  assign totalWrite = busWrite & (addr_i == ADDR_TOTAL);

  assign fifoEmpty  = (countReg == '0);
  assign fifoFull   = (countReg == CNT_W'(PROFUNDIDAD));

  // A pop only happens when there is something to pop; an empty-FIFO read
  // racing a push therefore sees the old (empty) state and returns 0.
  assign popEvt   = busRead & (addr_i == ADDR_DATA) & ~fifoEmpty;
  assign flushEvt = ctrlWrite & wdata_i[2];
  assign ovfClear = ctrlWrite & wdata_i[1];
  assign pushEvt  = pulso_i & (flushEvt | ~fifoFull | popEvt);
  assign dropEvt  = pulso_i & fifoFull & ~popEvt & ~flushEvt;

  // After a flush the surviving push lands in slot 0
  assign wrAddr = flushEvt ? '0 : wrPtrReg;

  always_comb begin
    wrPtrNext = wrPtrReg;
    rdPtrNext = rdPtrReg;
    countNext = countReg;
    if (flushEvt) begin
      rdPtrNext = '0;
      wrPtrNext = pushEvt ? PTR_W'(1) : '0;
      countNext = pushEvt ? CNT_W'(1) : '0;
    end else begin
      if (pushEvt) begin
        wrPtrNext = wrPtrReg + PTR_W'(1);
      end
      if (popEvt) begin
        rdPtrNext = rdPtrReg + PTR_W'(1);
      end
      case ({pushEvt, popEvt})
        2'b10:   countNext = countReg + CNT_W'(1);
        2'b01:   countNext = countReg - CNT_W'(1);
        default: countNext = countReg;
      endcase
    end
  end

  // A new overflow in the same cycle as a clear request stays recorded
  always_comb begin
    ovfNext = ovfReg;
    if (dropEvt) begin
      ovfNext = 1'b1;
    end else if (ovfClear) begin
      ovfNext = 1'b0;
    end
  end

  always_comb begin
    irqEnNext = irqEnReg;
    if (ctrlWrite) begin
      irqEnNext = wdata_i[0];
    end
  end

  always_comb begin
    totalNext = totalReg;
    if (totalWrite) begin
      totalNext = {15'd0, pulso_i};
    end else if (pulso_i) begin
      totalNext = totalReg + 16'd1;
    end
  end

  assign statusWord = {23'd0, 5'(countReg), 1'b0, ovfReg, fifoFull, ~fifoEmpty};
  assign dataWord   = popEvt ? {28'd0, fifoMem[rdPtrReg]} : 32'd0;

  always_comb begin
    readMux = 32'd0;
    case (addr_i)
      ADDR_STATUS: readMux = statusWord;
      ADDR_DATA:   readMux = dataWord;
      ADDR_CTRL:   readMux = {31'd0, irqEnReg};
      ADDR_TOTAL:  readMux = {16'd0, totalReg};
      default:     readMux = 32'd0;
    endcase
  end

  always_comb begin
    rdataNext = rdataReg;
    if (busRead) begin
      rdataNext = readMux;
    end
  end

  assign irqNext = irqEnReg & ~fifoEmpty;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wrPtrReg <= '0;
      rdPtrReg <= '0;
      countReg <= '0;
      ovfReg   <= 1'b0;
      irqEnReg <= 1'b0;
      totalReg <= 16'd0;
      rdataReg <= 32'd0;
      irqReg   <= 1'b0;
    end else begin
      wrPtrReg <= wrPtrNext;
      rdPtrReg <= rdPtrNext;
      countReg <= countNext;
      ovfReg   <= ovfNext;
      irqEnReg <= irqEnNext;
      totalReg <= totalNext;
      rdataReg <= rdataNext;
      irqReg   <= irqNext;
    end
  end

  // Storage is never reset; count=0 keeps stale entries unreachable
  always_ff @(posedge clk_i) begin
    if (rst_n_i && pushEvt) begin
      fifoMem[wrAddr] <= botones_i;
    end
  end

  assign rdata_o = rdataReg;
  assign irq_o   = irqReg;

endmodule

// File: tb/tb_interfaz_botones.sv
// Bench for interfaz_botones: directed scenarios plus random traffic, all checked
// against a queue-based reference model of the register interface.
module tb_interfaz_botones;

  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        pulso_i;
  logic [3:0]  botones_i;
  logic        cs_i;
  logic        we_i;
  logic [1:0]  addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        irq_o;

  int checks = 0;
  int errors = 0;

  logic [3:0]  mq[$];
  logic        mOvf = 1'b0;
  logic        mIrqEn = 1'b0;
  logic [15:0] mTotal = 16'd0;
  logic [31:0] expRdata = 32'd0;
  logic        expIrq = 1'b0;

  interfaz_botones #(.PROFUNDIDAD(DEPTH)) dut (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .pulso_i   (pulso_i),
    .botones_i (botones_i),
    .cs_i      (cs_i),
    .we_i      (we_i),
    .addr_i    (addr_i),
    .wdata_i   (wdata_i),
    .rdata_o   (rdata_o),
    .irq_o     (irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: one clock edge of the register interface, using queue ops
  task automatic modelStep();
    int n;
    logic [31:0] rv;
    logic irqNew;
    if (!rst_n_i) begin
      mq.delete();
      mOvf = 1'b0; mIrqEn = 1'b0; mTotal = 16'd0;
      expRdata = 32'd0; expIrq = 1'b0;
      return;
    end
    n = mq.size();
    irqNew = mIrqEn && (n > 0);
    rv = 32'd0;
    case (addr_i)
      2'd0: rv = {23'd0, 5'(n), 1'b0, mOvf, (n == DEPTH), (n > 0)};
      2'd1: rv = (n > 0) ? {28'd0, mq[0]} : 32'd0;
      2'd2: rv = {31'd0, mIrqEn};
      default: rv = {16'd0, mTotal};
    endcase
    if (cs_i && !we_i) begin
      expRdata = rv;
      if (addr_i == 2'd1 && n > 0) void'(mq.pop_front());
    end
    if (cs_i && we_i && addr_i == 2'd2) begin
      if (wdata_i[2]) mq.delete();
      if (wdata_i[1]) mOvf = 1'b0;
      mIrqEn = wdata_i[0];
    end
    if (pulso_i) begin
      if (mq.size() < DEPTH) mq.push_back(botones_i);
      else mOvf = 1'b1;
    end
    if (cs_i && we_i && addr_i == 2'd3) mTotal = pulso_i ? 16'd1 : 16'd0;
    else if (pulso_i) mTotal = mTotal + 16'd1;
    expIrq = irqNew;
  endtask

  task automatic drive(input logic r, input logic p, input logic [3:0] b, input logic c,
                       input logic w, input logic [1:0] a, input logic [31:0] d);
    rst_n_i = r; pulso_i = p; botones_i = b; cs_i = c; we_i = w; addr_i = a; wdata_i = d;
    @(posedge clk_i);
    modelStep();
    #1;
  endtask

  task automatic cyc(input logic r, input logic p, input logic [3:0] b, input logic c,
                     input logic w, input logic [1:0] a, input logic [31:0] d);
    drive(r, p, b, c, w, a, d);
    check("model_rdata", rdata_o, expRdata);
    check("model_irq", {31'd0, irq_o}, {31'd0, expIrq});
  endtask

  task automatic idle();                    cyc(1, 0, 4'd0, 0, 0, 2'd0, 0); endtask
  task automatic push(input logic [3:0] c); cyc(1, 1, c,    0, 0, 2'd0, 0); endtask
  task automatic rd(input logic [1:0] a);   cyc(1, 0, 4'd0, 1, 0, a,    0); endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d); cyc(1, 0, 4'd0, 1, 1, a, d); endtask

  initial begin
    logic [3:0] codes [4];
    logic r, p, c, w;
    logic [1:0] a;
    logic [31:0] d;
    codes[0] = 4'd8; codes[1] = 4'd4; codes[2] = 4'd2; codes[3] = 4'd1;

    // Reset state
    cyc(0, 0, 4'd0, 0, 0, 2'd0, 0);
    cyc(0, 1, 4'd5, 1, 1, 2'd2, 32'h7);
    check("reset_rdata", rdata_o, 32'd0);
    check("reset_irq", {31'd0, irq_o}, 32'd0);
    rd(2'd0);
    check("reset_status", rdata_o, 32'd0);

    // Codes 8,4,2,1 come out in order
    for (int i = 0; i < 4; i++) push(codes[i]);
    for (int i = 0; i < 4; i++) begin
      rd(2'd1);
      check("order_data", rdata_o, {28'd0, codes[i]});
    end
    rd(2'd0);
    check("order_status_empty", rdata_o, 32'h000);
    rd(2'd1);
    check("empty_data_read", rdata_o, 32'd0);

    // Overflow: six pushes into depth 4
    wr(2'd3, 32'd0);
    for (int i = 1; i <= 6; i++) push(4'(i));
    rd(2'd0);
    check("ovf_status", rdata_o, 32'h047);
    for (int i = 1; i <= 4; i++) begin
      rd(2'd1);
      check("ovf_data", rdata_o, 32'(i));
    end
    rd(2'd3);
    check("ovf_total", rdata_o, 32'd6);
    wr(2'd2, 32'h2);
    rd(2'd0);
    check("ovf_cleared", rdata_o, 32'h000);

    // Full FIFO with simultaneous push and pop
    for (int i = 9; i <= 12; i++) push(4'(i));
    cyc(1, 1, 4'd13, 1, 0, 2'd1, 0);
    check("full_pushpop_data", rdata_o, 32'd9);
    rd(2'd0);
    check("full_pushpop_status", rdata_o, 32'h043);

    // Flush, then flush racing a push
    wr(2'd2, 32'h4);
    rd(2'd0);
    check("flush_status", rdata_o, 32'h000);
    for (int i = 0; i < 3; i++) push(4'd3);
    cyc(1, 1, 4'd5, 1, 1, 2'd2, 32'h4);
    rd(2'd0);
    check("flush_push_status", rdata_o, 32'h011);
    rd(2'd1);
    check("flush_push_data", rdata_o, 32'd5);

    // Empty FIFO: push and DATA read in one cycle
    cyc(1, 1, 4'd0, 1, 0, 2'd1, 0);
    check("empty_pushpop_data", rdata_o, 32'd0);
    rd(2'd0);
    check("empty_pushpop_status", rdata_o, 32'h011);
    rd(2'd1);
    check("code_zero_data", rdata_o, 32'd0);

    // Interrupt timing
    wr(2'd2, 32'h1);
    rd(2'd2);
    check("ctrl_readback", rdata_o, 32'd1);
    push(4'd7);
    check("irq_pulse_cycle", {31'd0, irq_o}, 32'd0);
    idle();
    check("irq_asserted", {31'd0, irq_o}, 32'd1);
    rd(2'd1);
    check("irq_still_high", {31'd0, irq_o}, 32'd1);
    idle();
    check("irq_deasserted", {31'd0, irq_o}, 32'd0);
    wr(2'd2, 32'h0);

    // TOTAL wrap and write-with-pulse
    wr(2'd3, 32'd0);
    for (int i = 0; i < 65535; i++) drive(1, 1, 4'd1, 0, 0, 2'd0, 0);
    rd(2'd3);
    check("total_ffff", rdata_o, 32'h0000FFFF);
    push(4'd2);
    rd(2'd3);
    check("total_wrap", rdata_o, 32'h0);
    cyc(1, 1, 4'd3, 1, 1, 2'd3, 32'h1234);
    rd(2'd3);
    check("total_write_pulse", rdata_o, 32'd1);
    wr(2'd2, 32'h6);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 59) != 0);
      p = $urandom_range(0, 1);
      c = $urandom_range(0, 1);
      w = $urandom_range(0, 2) == 0;
      a = 2'($urandom_range(0, 3));
      d = 32'($urandom_range(0, 7));
      if (c && w && a == 2'd2 && $urandom_range(0, 3) != 0) d[2] = 1'b0;
      if (c && w && a == 2'd2 && d[1]) p = 1'b0;
      cyc(r, p, 4'($urandom_range(0, 15)), c, w, a, d);
    end

    // Reset with three events queued and interrupt pending
    wr(2'd2, 32'h5);
    for (int i = 0; i < 3; i++) push(4'(i + 1));
    idle();
    check("pre_reset_irq", {31'd0, irq_o}, 32'd1);
    cyc(0, 1, 4'd9, 1, 0, 2'd1, 0);
    rd(2'd0);
    check("post_reset_status", rdata_o, 32'd0);
    check("post_reset_irq", {31'd0, irq_o}, 32'd0);
    rd(2'd1);
    check("post_reset_data", rdata_o, 32'd0);
    rd(2'd2);
    check("post_reset_ctrl", rdata_o, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/interfaz_botones.md
INTERFAZ_BOTONES -- requirements
Module: interfaz_botones

Interface
REQ-001 SHALL have parameter PROFUNDIDAD, default 4, event FIFO depth; power of two, range 2..16.
REQ-002 SHALL have port clk_i  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n_i  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port pulso_i  input  1  one-cycle press pulse from the button filter stage.
REQ-005 SHALL have port botones_i  input  4  synchronized button levels {U,D,L,R}, bit3=U, bit0=R.
REQ-006 SHALL have port cs_i  input  1  bus select, one access per asserted cycle.
REQ-007 SHALL have port we_i  input  1  1=write, 0=read, qualified by cs_i.
REQ-008 SHALL have port addr_i  input  2  register select: 0 STATUS, 1 DATA, 2 CTRL, 3 TOTAL.
REQ-009 SHALL have port wdata_i  input  32  write data.
REQ-010 SHALL have port rdata_o  output  32  registered read data.
REQ-011 SHALL have port irq_o  output  1  registered interrupt request, level.

Function
REQ-012 SHALL push botones_i into the FIFO in the cycle pulso_i=1, including code 4'b0000.
REQ-013 SHALL pop the FIFO head on a read of DATA (cs_i=1, we_i=0, addr_i=1) when the FIFO is not empty.
REQ-014 SHALL return {28'b0, head code} on rdata_o in the cycle after a DATA read; latency 1 cycle for every register.
REQ-015 SHALL return 0 on a DATA read when the FIFO is empty, with no state change.
REQ-016 SHALL, when full with simultaneous push and pop, perform both, keep count unchanged and not set overflow.
REQ-017 SHALL, when empty with simultaneous push and pop, push only, return 0, and end with count=1.
REQ-018 SHALL, on a push when full without a pop, drop the event and set sticky bit ovf.
REQ-019 SHALL return for STATUS: bit0 = not empty, bit1 = full, bit2 = ovf, bits[8:4] = count (0..PROFUNDIDAD), other bits 0.
REQ-020 SHALL treat CTRL bit0 as irq_en (read/write).
REQ-021 SHALL clear ovf on a CTRL write with wdata_i bit1=1; flush on a CTRL write with bit2=1 (count=0, pointers=0). Bits 1 and 2 read back as 0.
REQ-022 SHALL give a same-cycle push priority over flush: the flushed FIFO ends with count=1 holding the new code.
REQ-023 SHALL increment the 16-bit TOTAL counter on every pulso_i, including dropped events; 16'hFFFF wraps to 0.
REQ-024 SHALL zero TOTAL on any TOTAL write; a same-cycle pulso_i makes TOTAL 1.
REQ-025 SHALL return TOTAL on read as {16'b0, TOTAL}.
REQ-026 SHALL ignore writes to STATUS and DATA.
REQ-027 SHALL hold rdata_o when cs_i=0 or we_i=1.
REQ-028 SHALL drive irq_o = irq_en AND not-empty, registered: asserted one cycle after the enabling condition, deasserted one cycle after it ends.
REQ-029 SHALL wrap FIFO pointers modulo PROFUNDIDAD; count width SHALL be clog2(PROFUNDIDAD)+1.

Reset
REQ-030 SHALL, while rst_n_i=0 at a clock edge, set count=0, pointers=0, ovf=0, irq_en=0, TOTAL=0, rdata_o=0, irq_o=0.
REQ-031 SHALL discard pulso_i and bus accesses during reset; reset mid-operation loses queued events.
REQ-032 SHALL not reset FIFO storage contents, and SHALL never expose them while count=0.

Verification
REQ-033 SHALL cover: pulses with codes 8,4,2,1, then four DATA reads -> rdata_o 8,4,2,1; STATUS then 0x000.
REQ-034 SHALL cover, at PROFUNDIDAD=4: six pulses, codes 1..6 -> STATUS=0x047, DATA reads 1,2,3,4, TOTAL=6.
REQ-035 SHALL cover: full FIFO, then push and DATA read in the same cycle -> count stays 4, ovf=0, old head returned.
REQ-036 SHALL cover: CTRL write 0x1, then one pulse -> irq_o=1 two cycles after the pulse; DATA read -> irq_o=0 two cycles after the read.
REQ-037 SHALL cover: TOTAL=0xFFFF, then one pulse -> TOTAL=0x0000; TOTAL write plus simultaneous pulse -> TOTAL=1.
REQ-038 SHALL cover: rst_n_i=0 for one cycle with 3 events queued -> STATUS=0, irq_o=0, DATA read returns 0.
